// File: rtl/ro_ctrl_pkg.sv
// Shared definitions for the RO capture controller: sequencer states and default widths.
package ro_ctrl_pkg;

    localparam int DEF_CNT_WIDTH     = 32;
    localparam int DEF_TIMEOUT_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRE,
        TRIG,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/capture_sequencer.sv
// Sequences one RO capture run: sensor start, delayed RSA trigger, sample counting,
// DMA drain with timeout, and sticky status reporting.
module capture_sequencer
    import ro_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] num_samples,
    input  logic [CNT_WIDTH-1:0] pre_trigger,
    input  logic                 sample_valid,
    input  logic                 rsa_done,
    input  logic                 wr_done,
    output logic                 ro_go,
    output logic                 rsa_go,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 rsa_seen,
    output logic [CNT_WIDTH-1:0] sample_count
);

    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    // Value of the drain counter in the last DRAIN cycle before timeout.
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_num;
    logic [CNT_WIDTH-1:0]   r_pre;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0] r_to;
    logic                   r_err;
    logic                   r_seen;
    logic                   w_go_acc;
    logic                   w_abort;
    logic                   w_counting;
    logic                   w_full;
    logic                   w_to_exp;

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = abort && (r_state != IDLE);
        w_go_acc    = go && !abort && ((r_state == IDLE) || (r_state == DONE));
        w_counting  = (r_state == PRE) || (r_state == TRIG) || (r_state == CAPTURE);
        w_cnt_nxt   = r_cnt;
        if (w_counting && sample_valid && (r_cnt < r_num))
            w_cnt_nxt = r_cnt + CNT_ONE;
        w_full      = w_counting && (w_cnt_nxt == r_num);
        w_to_exp    = (r_to == TO_LAST);

        case (r_state)
            IDLE, DONE: if (w_go_acc) w_state_nxt = (num_samples == '0) ? DONE : ARM;
            ARM:        w_state_nxt = (r_pre == '0) ? TRIG : PRE;
            // A fill during PRE wins over the trigger, so rsa_go is never issued.
            PRE:        if (w_full) w_state_nxt = DRAIN;
                        else if (r_pre == CNT_ONE) w_state_nxt = TRIG;
            TRIG:       w_state_nxt = w_full ? DRAIN : CAPTURE;
            CAPTURE:    if (w_full) w_state_nxt = DRAIN;
            DRAIN:      if (wr_done || w_to_exp) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase

        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_num   <= '0;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_to    <= '0;
            r_err   <= 1'b0;
            r_seen  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_go_acc) begin
                r_num  <= num_samples;
                r_pre  <= pre_trigger;
                r_cnt  <= '0;
                r_err  <= 1'b0;
                r_seen <= 1'b0;
            end else if (!w_abort) begin
                r_cnt <= w_cnt_nxt;
                if ((r_state == PRE) && (r_pre != '0))
                    r_pre <= r_pre - CNT_ONE;
                if (rsa_done && ((r_state == TRIG) || (r_state == CAPTURE) || (r_state == DRAIN)))
                    r_seen <= 1'b1;
                if ((r_state == DRAIN) && !wr_done && w_to_exp)
                    r_err <= 1'b1;
            end
            r_to <= ((r_state == DRAIN) && !w_abort) ? r_to + TO_ONE : '0;
        end
    end

    assign ro_go        = (r_state == ARM);
    assign rsa_go       = (r_state == TRIG);
    assign busy         = (r_state != IDLE) && (r_state != DONE);
    assign done         = (r_state == DONE);
    assign err_timeout  = r_err;
    assign rsa_seen     = r_seen;
    assign sample_count = r_cnt;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer: a run-level timeline model queues expected
// pulses and completion status; a negedge monitor pops and compares them.
module tb_capture_sequencer;

    localparam int CW      = 8;
    localparam int TW      = 4;
    localparam int TO      = (1 << TW) - 1;
    localparam int MAXC    = 256;
    localparam int EV_RO   = 0;
    localparam int EV_RSA  = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
        int err;
        int seen;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          sample_valid = 1'b0;
    logic          rsa_done = 1'b0;
    logic          wr_done = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic [CW-1:0] pre_trigger = '0;
    logic          ro_go, rsa_go, busy, done, err_timeout, rsa_seen;
    logic [CW-1:0] sample_count;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic prev_done = 1'b0;
    bit   idle_now;
    ev_t  exp_q[$];

    capture_sequencer #(.CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
        .num_samples(num_samples), .pre_trigger(pre_trigger),
        .sample_valid(sample_valid), .rsa_done(rsa_done), .wr_done(wr_done),
        .ro_go(ro_go), .rsa_go(rsa_go), .busy(busy), .done(done),
        .err_timeout(err_timeout), .rsa_seen(rsa_seen), .sample_count(sample_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int cnt, input int err, input int seen);
        ev_t e;
        e.kind = kind; e.cyc = c; e.cnt = cnt; e.err = err; e.seen = seen;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == EV_DONE) begin
                chk("done_sample_count", int'(sample_count), e.cnt);
                chk("done_err_timeout", int'(err_timeout), e.err);
                chk("done_rsa_seen", int'(rsa_seen), e.seen);
                chk("done_busy", int'(busy), 0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) prev_done <= 1'b0;
        else begin
            if (ro_go) pop_ev(EV_RO);
            if (rsa_go) pop_ev(EV_RSA);
            if (done && !prev_done) pop_ev(EV_DONE);
            prev_done <= done;
        end
    end

    function automatic bit keep(input int rel, input int mode, input int a);
        if (mode == 1) return rel <= a;
        if (mode == 2) return rel < a;
        return 1'b1;
    endfunction

    task automatic drive_idle();
        go = 0; abort = 0; sample_valid = 0; rsa_done = 0; wr_done = 0;
    endtask

    // mode: 0 run to completion, 1 abort at relative cycle, 2 reset at relative cycle
    task automatic run(input int num, input int pre, input int pv, input int pw, input int pr,
                       input int mode_in, input int kill_in);
        bit sv[MAXC], rd[MAXC], wd[MAXC], gg[MAXC];
        int f, t, d, e, a, c, last, lim, g, lo, cntv, err, seen, mode;
        bit has_t;
        mode = mode_in;
        for (int k = 0; k < MAXC; k++) begin
            sv[k] = (k >= 200) || ($urandom_range(99, 0) < pv);
            rd[k] = ($urandom_range(99, 0) < pr);
            wd[k] = ($urandom_range(99, 0) < pw);
            gg[k] = ($urandom_range(99, 0) < 10);
        end
        err = 0; seen = 0; has_t = 0; t = 2 + pre; d = 0; f = 0;
        if (num == 0) begin
            e = 1;
            mode = 0;
        end else begin
            cntv = 0; f = -1;
            for (int k = 2; k < MAXC && f < 0; k++) begin
                if (sv[k]) cntv++;
                if (cntv == num) f = k;
            end
            d = f + 1;
            has_t = (f >= t);
            e = -1;
            for (int k = d; k <= d + TO - 1 && e < 0; k++) if (wd[k]) e = k + 1;
            if (e < 0) begin
                e = d + TO;
                err = 1;
            end
            lo = has_t ? t : d;
            for (int k = lo; k < e; k++) if (rd[k]) seen = 1;
        end
        a = 0;
        if (mode == 1) a = (kill_in >= 0) ? kill_in : int'($urandom_range(e - 1, 1));
        if (mode == 2) a = (kill_in >= 0) ? kill_in : int'($urandom_range(e - 1, 2));
        c = 0;
        for (int k = 2; k < a; k++) if (sv[k]) c++;
        if (c > num) c = num;
        last = (mode == 0) ? e : a;
        lim  = (mode == 0) ? e : a;
        g = 0;

        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                g = cyc;
                if (num > 0 && keep(1, mode, a)) push_ev(EV_RO, g + 1, 0, 0, 0);
                if (num > 0 && has_t && keep(t, mode, a)) push_ev(EV_RSA, g + t, 0, 0, 0);
                if (keep(e, mode, a)) push_ev(EV_DONE, g + e, num, err, seen);
            end
            go           = (k == 0) || (k < lim && gg[k]);
            abort        = (mode == 1) && (k == a);
            sample_valid = sv[k];
            rsa_done     = rd[k];
            wr_done      = wd[k];
            num_samples  = (k == 0) ? CW'(num) : CW'($urandom);
            pre_trigger  = (k == 0) ? CW'(pre) : CW'($urandom);
            if (mode == 2 && k == a) begin
                rst_n = 0;
                #1;
                chk("reset_pulses_flags", int'({ro_go, rsa_go, busy, done, err_timeout, rsa_seen}), 0);
                chk("reset_sample_count", int'(sample_count), 0);
            end else if (k == 1 || (mode == 1 && k == a)) begin
                @(negedge clk);
                if (k == 1) begin
                    chk("go_done", int'(done), (num == 0) ? 1 : 0);
                    chk("go_busy", int'(busy), (num == 0) ? 0 : 1);
                    chk("go_clears_err", int'(err_timeout), 0);
                    chk("go_clears_seen", int'(rsa_seen), 0);
                    chk("go_clears_count", int'(sample_count), 0);
                end
                if (mode == 1 && k == a) chk("count_at_abort", int'(sample_count), c);
            end
        end

        if (mode == 1) begin
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            chk("abort_busy", int'(busy), 0);
            chk("abort_done", int'(done), 0);
            chk("abort_count_held", int'(sample_count), c);
            idle_now = 1;
            repeat (2) @(posedge clk);
        end else if (mode == 2) begin
            drive_idle();
            repeat (2) @(posedge clk);
            #1 rst_n = 1;
            idle_now = 1;
            repeat (3) @(posedge clk);
        end else begin
            @(posedge clk); #1;
            drive_idle();
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("done_held", int'(done), 1);
            idle_now = 0;
        end
    endtask

    initial begin
        int num, r, mode;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_pulses_flags", int'({ro_go, rsa_go, busy, done, err_timeout, rsa_seen}), 0);
        chk("por_sample_count", int'(sample_count), 0);
        rst_n = 1;
        idle_now = 1;

        run(0, 0, 100, 0, 0, 0, -1);     // empty run from IDLE
        run(8, 3, 100, 30, 20, 0, -1);   // nominal
        run(2, 10, 100, 30, 0, 0, -1);   // fill during PRE, no trigger
        run(5, 2, 100, 0, 20, 0, -1);    // drain timeout
        run(4, 1, 80, 20, 10, 0, -1);    // rerun from DONE after timeout
        run(8, 0, 100, 20, 10, 1, 5);    // abort in CAPTURE with 3 samples
        run(8, 10, 100, 20, 10, 2, 4);   // reset during PRE
        run(0, 5, 50, 10, 10, 0, -1);    // empty run after reset

        for (int i = 0; i < 30; i++) begin
            num = $urandom_range(20, 0);
            if (num == 0 && !idle_now) num = 1;
            r = $urandom_range(9, 0);
            mode = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
            run(num, $urandom_range(15, 0), $urandom_range(100, 30), $urandom_range(20, 0),
                $urandom_range(30, 0), mode, -1);
        end

        drive_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
